uart_tx_fifo: RTL

Byte-buffered transmit front end that sits directly upstream of the `uart` wrapper and drives its `tx_start` / `data_in` inputs. Producers write bytes into a small FIFO at any rate. A sequencer FSM pops one byte at a time and launches it on the UART. It watches the UART's `tx_busy` output and does not issue the next `tx_start` until the previous frame has finished.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths and the transmit sequencer state encoding.
package uart_pkg;

    localparam int UART_DBIT   = 8;
    localparam int UART_FIFO_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } tx_seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered occupancy flags and a drop-on-full write port.
module sync_fifo #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              rd_en,
    output logic [DBIT-1:0]   rd_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_W:0]   level,
    output logic              overflow
);

    localparam int              DEPTH     = 1 << FIFO_W;
    localparam logic [FIFO_W:0] DEPTH_CNT = (FIFO_W+1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W:0]   count;
    logic [FIFO_W:0]   count_nxt;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance is judged on the registered full flag, so a same-cycle pop never rescues a write.
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok)
            count_nxt = count + 1'b1;
        else if (!wr_ok && rd_ok)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            full     <= (count_nxt == DEPTH_CNT);
            empty    <= (count_nxt == '0);
            overflow <= wr_en & full;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front end: queues bytes and launches one frame at a time,
// waiting for the UART's busy handshake (or a short timeout) between frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int FIFO_W  = UART_FIFO_W,
    parameter int ACK_TMO = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_W:0]   level,
    output logic              overflow,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_data
);

    localparam int               CNT_W    = $clog2(ACK_TMO) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);

    tx_seq_state_t    state;
    tx_seq_state_t    state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_nxt;
    logic             pop;
    logic [DBIT-1:0]  head;

    sync_fifo #(
        .DBIT   (DBIT),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt   = WAIT_ACK;
                tmo_cnt_nxt = '0;
            end
            // A UART that never raises busy still releases us; the frame is not retried.
            WAIT_ACK: begin
                if (tx_busy)
                    state_nxt = WAIT_DONE;
                else if (tmo_cnt == TMO_LAST)
                    state_nxt = IDLE;
                else
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
            WAIT_DONE: begin
                if (!tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            tx_data <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (pop)
                tx_data <= head;
        end
    end

    assign tx_start = (state == START);

endmodule
